ir_cmd_validator: RTL and testbench
===================================

// Module: ir_cmd_validator
// PURPOSE
//  Downstream of the NEC IR frame decoder. Consumes each decoded command byte and its inverted copy.
//  Checks the pair for complement integrity and turns valid frames into clean key events:
//  press, auto-repeat, release. Counts corrupt frames. Feeds the application/LED control logic.
// PARAMETERS
//  TIMEOUT     5_400_000  clk cycles with no valid same-key frame before release (108 ms @ 50 MHz)
//  REPEAT_MIN  2          consecutive same-key frames after the press before key_repeat starts
//  TW          23         hold timer width; must satisfy 2**TW > TIMEOUT
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  comando     in   8  decoded command byte from the upstream decoder
//  comparador  in   8  decoded inverted command byte from the upstream decoder
//  frame_done  in   1  1-cycle strobe; comando/comparador valid this cycle
//  key_code    out  8  current/last key; stable from key_valid until the next key_valid
//  key_valid   out  1  1-cycle pulse: new key pressed
//  key_repeat  out  1  1-cycle pulse: held key auto-repeat
//  key_release out  1  1-cycle pulse: key released; key_code still shows the released key
//  key_held    out  1  level, 1 while in HELD or SWITCH
//  frame_err   out  1  1-cycle pulse: complement check failed
//  err_count   out  8  corrupt-frame count, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timer 0, rep_cnt 0, capture registers 0.
//  Capture stage: on frame_done, register {comando, comparador} and set chk_v. chk_v lasts 1 cycle.
//  Frames may arrive every cycle with no loss, except in SWITCH (see below).
//  Check (cycle after capture): ok = (cap_cmd ^ cap_inv) == 8'hFF.
//  Output pulses assert the cycle after the check, so event latency is 2 clks from frame_done.
//  !ok: frame_err pulses; err_count += 1 unless it is already FF.
//    State, timer and key_code are untouched.
//  States:
//   IDLE:   ok -> key_code <= cap_cmd, key_valid pulse, timer <= 0, rep_cnt <= 0, go to HELD.
//   HELD:   timer += 1 each cycle.
//           ok & cap_cmd == key_code -> timer <= 0; rep_cnt += 1 (saturates at REPEAT_MIN);
//             key_repeat pulses when the incremented rep_cnt >= REPEAT_MIN.
//           ok & cap_cmd != key_code -> key_release pulse (old code on key_code);
//             latch pending = cap_cmd; go to SWITCH.
//           timer == TIMEOUT-1, no ok frame this cycle -> key_release pulse, go to IDLE.
//           ok frame and timeout in the same cycle -> the frame wins: no release, timer <= 0.
//   SWITCH: lasts 1 cycle. key_code <= pending, key_valid pulse, timer <= 0, rep_cnt <= 0, go to HELD.
//           A check result in this cycle is discarded: no event, no err_count change.
//  At most one of key_valid / key_repeat / key_release is high in any cycle.
//  Timer never wraps; it is held at 0 in IDLE.
//  Reset mid-operation: immediate return to reset values. No release pulse is emitted.
// STRUCTURE
//  Shared package ir_pkg: state encodings (IDLE=2'd0, HELD=2'd1, SWITCH=2'd2);
//    NEC_INV_MASK = 8'hFF; default TIMEOUT for 50 MHz.
//  Sub-module hold_timer (clr, en, TW-bit count, expired flag at TIMEOUT-1).
//  FSM, capture/check pipeline and error counter stay in the top module.
// TESTING (bench uses TIMEOUT=100, REPEAT_MIN=2)
//  1. comando=45, comparador=BA, one frame_done
//     -> key_valid 1 pulse 2 clks later; key_code=45; key_held=1.
//  2. comando=45, comparador=BB
//     -> frame_err pulse; err_count=1; no key_valid; state unchanged.
//     After 300 bad frames -> err_count=FF.
//  3. 45/BA frames every 50 clks, 4 frames
//     -> key_valid on frame 1; no pulse on frame 2; key_repeat on frames 3 and 4.
//  4. Single 45/BA frame, then idle
//     -> key_release exactly 100 clks after the key_valid cycle; key_held=0; key_code stays 45.
//  5. Hold 45, then a 16/E9 frame
//     -> key_release (key_code=45), next clk key_valid with key_code=16.
//  6. Assert reset 10 clks into HELD
//     -> next clk all outputs 0, err_count=0, no key_release.
//     A following 45/BA frame gives a fresh key_valid.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR command validator.
// Holds the FSM encoding, frame payload layout and default timing parameters.
package ir_pkg;

  localparam int unsigned CMD_W          = 8;
  localparam logic [CMD_W-1:0] NEC_INV_MASK = 8'hFF;
  localparam int unsigned TIMEOUT_DEF    = 5_400_000;  // 108 ms at 50 MHz
  localparam int unsigned REPEAT_MIN_DEF = 2;
  localparam int unsigned TW_DEF         = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    SWITCH = 2'd2
  } ir_state_e;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [CMD_W-1:0] inv;
  } ir_frame_t;

  // A frame is intact when the inverted byte is the exact complement of the command.
  function automatic logic frame_ok(input ir_frame_t f);
    return (f.cmd ^ f.inv) == NEC_INV_MASK;
  endfunction

endpackage

// File: rtl/ir_cmd_validator_hold_timer.sv
// Key-hold timer: counts cycles while enabled, clears on request.
// expired_o is registered so it is high exactly while count_o == TIMEOUT-1.
module hold_timer #(
  parameter int unsigned TW      = 23,
  parameter int unsigned TIMEOUT = 5_400_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [TW-1:0] count_o,
  output logic          expired_o
);

  logic [TW-1:0] count_q, count_d;
  logic          expired_q, expired_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TW'(1);
    end
    expired_d = (count_d == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/ir_cmd_validator.sv
// Validates decoded NEC command/inverse pairs and turns them into press,
// auto-repeat and release key events; counts corrupt frames.
module ir_cmd_validator
  import ir_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned REPEAT_MIN = REPEAT_MIN_DEF,
  parameter int unsigned TW         = TW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] comando,
  input  logic [CMD_W-1:0] comparador,
  input  logic             frame_done,
  output logic [CMD_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_repeat,
  output logic             key_release,
  output logic             key_held,
  output logic             frame_err,
  output logic [7:0]       err_count
);

  localparam int unsigned RCW = (REPEAT_MIN < 2) ? 1 : $clog2(REPEAT_MIN + 1);

  ir_state_e        state_q, state_d;
  ir_frame_t        cap_q;
  logic             chk_v_q;
  logic [CMD_W-1:0] key_code_q, key_code_d;
  logic [CMD_W-1:0] pending_q, pending_d;
  logic [RCW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [RCW-1:0]   rep_inc;
  logic             key_valid_q, key_valid_d;
  logic             key_repeat_q, key_repeat_d;
  logic             key_release_q, key_release_d;
  logic             key_held_q, key_held_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             ok_c, bad_c;
  logic             tmr_clr, tmr_en, tmr_expired;
  logic [TW-1:0]    tmr_count;

  hold_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .count_o   (tmr_count),
    .expired_o (tmr_expired)
  );

  // Capture stage: one-cycle check window behind each frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q   <= '0;
      chk_v_q <= 1'b0;
    end else begin
      chk_v_q <= frame_done;
      if (frame_done) begin
        cap_q <= '{cmd: comando, inv: comparador};
      end
    end
  end

  assign ok_c    = chk_v_q & frame_ok(cap_q);
  assign bad_c   = chk_v_q & ~frame_ok(cap_q);
  assign rep_inc = (rep_cnt_q < RCW'(REPEAT_MIN)) ? rep_cnt_q + RCW'(1) : rep_cnt_q;

  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    pending_d     = pending_q;
    rep_cnt_d     = rep_cnt_q;
    key_valid_d   = 1'b0;
    key_repeat_d  = 1'b0;
    key_release_d = 1'b0;
    frame_err_d   = 1'b0;
    err_count_d   = err_count_q;
    tmr_clr       = 1'b1;
    tmr_en        = 1'b0;

    // Corrupt frames are counted everywhere except the one-cycle SWITCH slot.
    if (bad_c && (state_q != SWITCH)) begin
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ok_c) begin
          key_code_d  = cap_q.cmd;
          key_valid_d = 1'b1;
          rep_cnt_d   = '0;
          state_d     = HELD;
        end
      end
      HELD: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        if (ok_c) begin
          tmr_clr = 1'b1;
          if (cap_q.cmd == key_code_q) begin
            rep_cnt_d    = rep_inc;
            key_repeat_d = (rep_inc >= RCW'(REPEAT_MIN));
          end else begin
            key_release_d = 1'b1;
            pending_d     = cap_q.cmd;
            state_d       = SWITCH;
          end
        end else if (tmr_expired) begin
          tmr_clr       = 1'b1;
          key_release_d = 1'b1;
          state_d       = IDLE;
        end
      end
      SWITCH: begin
        key_code_d  = pending_q;
        key_valid_d = 1'b1;
        rep_cnt_d   = '0;
        state_d     = HELD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    key_held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      key_code_q    <= '0;
      pending_q     <= '0;
      rep_cnt_q     <= '0;
      key_valid_q   <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      pending_q     <= pending_d;
      rep_cnt_q     <= rep_cnt_d;
      key_valid_q   <= key_valid_d;
      key_repeat_q  <= key_repeat_d;
      key_release_q <= key_release_d;
      key_held_q    <= key_held_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
    end
  end

  // The hold timer must sit at zero whenever no key is held.
  a_timer_idle_zero: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> (tmr_count == '0));

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_repeat  = key_repeat_q;
  assign key_release = key_release_q;
  assign key_held    = key_held_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_ir_cmd_validator.sv
// Self-checking bench for ir_cmd_validator: table-driven frames plus hand-built
// timeout, saturation and reset sequences, checked through an event scoreboard.
module tb_ir_cmd_validator;

  localparam int unsigned TIMEOUT    = 100;
  localparam int unsigned REPEAT_MIN = 2;
  localparam int unsigned TW         = 8;

  localparam int EV_ERR   = 1;
  localparam int EV_REL   = 2;
  localparam int EV_VALID = 3;
  localparam int EV_REP   = 4;
  localparam int VK_NONE  = 0;
  localparam int VK_SWITCH = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] comando, comparador;
  logic       frame_done;
  logic [7:0] key_code;
  logic       key_valid, key_repeat, key_release, key_held, frame_err;
  logic [7:0] err_count;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    int          kind;
    logic [7:0]  code;
    logic        held;
    logic [7:0]  errc;
    int unsigned cyc;
  } ev_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] inv;
    int         gap;
    int         kind;
    logic [7:0] code;
    logic [7:0] rel_code;
    logic [7:0] errc;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[8];

  ir_cmd_validator #(
    .TIMEOUT    (TIMEOUT),
    .REPEAT_MIN (REPEAT_MIN),
    .TW         (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .comando     (comando),
    .comparador  (comparador),
    .frame_done  (frame_done),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_release (key_release),
    .key_held    (key_held),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] code, input logic held,
                      input logic [7:0] errc, input int unsigned c);
    ev_t e;
    e.kind = kind; e.code = code; e.held = held; e.errc = errc; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic match(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none at cycle %0d", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("key_code", key_code, e.code);
      chk("key_held", key_held, e.held);
      if (kind == EV_ERR) chk("err_count", err_count, e.errc);
    end
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: got nothing, expected kind %0d at cycle %0d",
               exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (frame_err)   match(EV_ERR);
    if (key_release) match(EV_REL);
    if (key_valid)   match(EV_VALID);
    if (key_repeat)  match(EV_REP);
    if (key_valid | key_repeat | key_release)
      chk("event_onehot", int'($countones({key_valid, key_repeat, key_release}) <= 1), 1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cmd, input logic [7:0] inv);
    comando    = cmd;
    comparador = inv;
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick(1);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0 at cycle %0d",
               exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_code"}, key_code, 0);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_key_repeat"}, key_repeat, 0);
    chk({tag, "_key_release"}, key_release, 0);
    chk({tag, "_key_held"}, key_held, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish by 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d;
    int unsigned last_ok;
    int          e;

    reset = 1'b1; comando = '0; comparador = '0; frame_done = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    vecs[0] = '{8'h45, 8'hBA, 50, EV_VALID,  8'h45, 8'h00, 8'd0};
    vecs[1] = '{8'h45, 8'hBA, 50, VK_NONE,   8'h45, 8'h00, 8'd0};
    vecs[2] = '{8'h45, 8'hBA, 50, EV_REP,    8'h45, 8'h00, 8'd0};
    vecs[3] = '{8'h45, 8'hBA, 50, EV_REP,    8'h45, 8'h00, 8'd0};
    vecs[4] = '{8'h45, 8'hBB,  5, EV_ERR,    8'h45, 8'h00, 8'd1};
    vecs[5] = '{8'h16, 8'hE9, 20, VK_SWITCH, 8'h16, 8'h45, 8'd0};
    vecs[6] = '{8'h16, 8'hE9, 20, VK_NONE,   8'h16, 8'h00, 8'd0};
    vecs[7] = '{8'h16, 8'hE9, 20, EV_REP,    8'h16, 8'h00, 8'd0};

    last_ok = 0;
    for (int i = 0; i < 8; i++) begin
      d = cyc;
      case (vecs[i].kind)
        EV_VALID, EV_REP: push(vecs[i].kind, vecs[i].code, 1'b1, 8'd0, d + 2);
        EV_ERR:           push(EV_ERR, vecs[i].code, 1'b1, vecs[i].errc, d + 2);
        VK_SWITCH: begin
          push(EV_REL, vecs[i].rel_code, 1'b1, 8'd0, d + 2);
          push(EV_VALID, vecs[i].code, 1'b1, 8'd0, d + 3);
        end
        default: ;
      endcase
      if (vecs[i].kind != EV_ERR) last_ok = d;
      send(vecs[i].cmd, vecs[i].inv);
      tick(vecs[i].gap - 1);
    end
    push(EV_REL, 8'h16, 1'b0, 8'd0, last_ok + 102);
    drain(300);
    chk("post_timeout_held", key_held, 0);
    chk("post_timeout_code", key_code, 8'h16);

    // Refresh frame checked in the exact timeout cycle: the frame wins.
    d = cyc;
    push(EV_VALID, 8'h45, 1'b1, 8'd0, d + 2);
    send(8'h45, 8'hBA);
    tick(99);
    send(8'h45, 8'hBA);
    push(EV_REL, 8'h45, 1'b0, 8'd0, d + 202);
    drain(300);

    // Refresh frame one cycle too late: release, then a fresh press.
    d = cyc;
    push(EV_VALID, 8'h45, 1'b1, 8'd0, d + 2);
    send(8'h45, 8'hBA);
    tick(100);
    push(EV_REL, 8'h45, 1'b0, 8'd0, d + 102);
    push(EV_VALID, 8'h45, 1'b1, 8'd0, d + 103);
    send(8'h45, 8'hBA);
    push(EV_REL, 8'h45, 1'b0, 8'd0, d + 203);
    drain(300);

    // Back-to-back corrupt frames drive err_count into saturation.
    e = 1;
    for (int i = 0; i < 300; i++) begin
      d = cyc;
      e = (e == 255) ? 255 : e + 1;
      push(EV_ERR, 8'h45, 1'b0, 8'(e), d + 2);
      send(8'(i), 8'(i));
    end
    drain(20);
    chk("err_saturated", err_count, 8'hFF);

    // Reset while a key is held: no release, all outputs cleared.
    d = cyc;
    push(EV_VALID, 8'h45, 1'b1, 8'd0, d + 2);
    send(8'h45, 8'hBA);
    tick(11);
    drain(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_all_zero("midreset");
    tick(150);
    d = cyc;
    push(EV_VALID, 8'h45, 1'b1, 8'd0, d + 2);
    send(8'h45, 8'hBA);
    tick(3);
    chk("fresh_err_count", err_count, 0);
    push(EV_REL, 8'h45, 1'b0, 8'd0, d + 102);
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
